pinmux_cfg: RTL and testbench

- Register-programmable pin multiplexer that replaces the fixed pad-to-peripheral wiring of the chip top level.
- Any peripheral output/output-enable pair can be routed to any pad.
- Any pad, or a constant, can be routed to any peripheral input.
- Sits between top_chip_system cio_* signals and padring pad_out/pad_oe/pad_in.
- Configured over a simple single-cycle register port from the peripheral bus.

---
 rtl/pinmux_cfg.sv | 202 ++++++++++++++++++++
 tb/tb_pinmux_cfg.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pinmux_cfg.sv
// pinmux_cfg: register-programmable pad <-> peripheral multiplexer with a
// single-cycle register port. Define PINMUX_DEBOUNCE_EN to add per-input debounce.
module pinmux_cfg #(
   parameter int NPads      = 64,
   parameter int NPeriphOut = 64,
   parameter int NPeriphIn  = 48,
   parameter int DebounceW  = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  reg_req_i,
   input  logic                  reg_we_i,
   input  logic [11:0]           reg_addr_i,
   input  logic [31:0]           reg_wdata_i,
   output logic [31:0]           reg_rdata_o,
   output logic                  reg_ready_o,
   output logic                  reg_err_o,
   input  logic [NPeriphOut-1:0] periph_out_i,
   input  logic [NPeriphOut-1:0] periph_oe_i,
   output logic [NPeriphIn-1:0]  periph_in_o,
   input  logic [NPads-1:0]      pad_in_i,
   output logic [NPads-1:0]      pad_out_o,
   output logic [NPads-1:0]      pad_oe_o,
   output logic                  locked_o
);

   localparam int OselW   = $clog2(NPeriphOut + 1);
   localparam int IselW   = $clog2(NPads + 2);
   localparam int PadIdxW = (NPads > 1) ? $clog2(NPads) : 1;
   localparam int InIdxW  = (NPeriphIn > 1) ? $clog2(NPeriphIn) : 1;
   localparam logic [OselW-1:0] OselMax = OselW'(NPeriphOut);
   localparam logic [IselW-1:0] IselMax = IselW'(NPads + 1);

   logic [NPads-1:0][OselW-1:0]     outsel_q;
   logic [NPeriphIn-1:0][IselW-1:0] insel_q;
   logic                            lock_q;

   logic [1:0]         region;
   logic [7:0]         idx;
   logic [PadIdxW-1:0] pad_idx;
   logic [InIdxW-1:0]  in_idx;
   logic               hit_out, hit_in, hit_lock, hit_db;
   logic               acc_err, wr_en;
   logic [31:0]        rd_data;

   logic               ready_q, err_q;
   logic [31:0]        rdata_q;

   logic [NPads-1:0]   sync1_q, sync2_q;
   logic [NPeriphOut:0] out_ext, oe_ext;
   logic [NPads+1:0]   in_ext;
   logic [NPeriphIn-1:0] muxed;

   assign region  = reg_addr_i[11:10];
   assign idx     = reg_addr_i[9:2];
   assign pad_idx = idx[PadIdxW-1:0];
   assign in_idx  = idx[InIdxW-1:0];

`ifdef PINMUX_DEBOUNCE_EN
   logic [DebounceW-1:0] debounce_q;
`endif

   // Address decode: 0x000 OUTSEL, 0x400 INSEL, 0x800 LOCK, 0x804 DEBOUNCE.
   always_comb begin
      hit_out  = 1'b0;
      hit_in   = 1'b0;
      hit_lock = 1'b0;
      hit_db   = 1'b0;
      case (region)
         2'b00:   hit_out  = int'(idx) < NPads;
         2'b01:   hit_in   = int'(idx) < NPeriphIn;
         2'b10: begin
            hit_lock = (idx == 8'd0);
            hit_db   = (idx == 8'd1);
         end
         default: ;
      endcase
   end

   assign acc_err = !(hit_out || hit_in || hit_lock || hit_db) ||
                    (reg_we_i && lock_q && (hit_out || hit_in || hit_db));
   assign wr_en   = reg_req_i && reg_we_i && !acc_err;

   always_comb begin
      rd_data = '0;
      if (hit_out) begin
         rd_data[OselW-1:0] = outsel_q[pad_idx];
      end else if (hit_in) begin
         rd_data[IselW-1:0] = insel_q[in_idx];
      end else if (hit_lock) begin
         rd_data[0] = lock_q;
      end else if (hit_db) begin
`ifdef PINMUX_DEBOUNCE_EN
         rd_data[DebounceW-1:0] = debounce_q;
`else
         rd_data = '0;
`endif
      end
   end

   // Handshake: reg_req_i is a one-cycle request; exactly one cycle later
   // reg_ready_o pulses with reg_rdata_o/reg_err_o, which are 0 at all other times.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         ready_q <= reg_req_i;
         err_q   <= reg_req_i && acc_err;
         rdata_q <= (reg_req_i && !acc_err && !reg_we_i) ? rd_data : '0;
      end
   end

   assign reg_ready_o = ready_q;
   assign reg_err_o   = err_q;
   assign reg_rdata_o = rdata_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         outsel_q <= '0;
         insel_q  <= '0;
         lock_q   <= 1'b0;
      end else if (wr_en) begin
         if (hit_out) outsel_q[pad_idx] <= reg_wdata_i[OselW-1:0];
         if (hit_in)  insel_q[in_idx]   <= reg_wdata_i[IselW-1:0];
         if (hit_lock && reg_wdata_i[0]) lock_q <= 1'b1;
      end
   end

   assign locked_o = lock_q;

   // Output path is purely combinational; entry 0 of the extended vectors is the "off" source.
   assign out_ext = {periph_out_i, 1'b0};
   assign oe_ext  = {periph_oe_i, 1'b0};

   for (genvar p = 0; p < NPads; p++) begin : g_out
      assign pad_out_o[p] = (outsel_q[p] <= OselMax) ? out_ext[outsel_q[p]] : 1'b0;
      assign pad_oe_o[p]  = (outsel_q[p] <= OselMax) ? oe_ext[outsel_q[p]]  : 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= pad_in_i;
         sync2_q <= sync1_q;
      end
   end

   // Input select 0/1 are constants, 2.. maps onto synchronised pads.
   assign in_ext = {sync2_q, 2'b10};

   for (genvar i = 0; i < NPeriphIn; i++) begin : g_in
      assign muxed[i] = (insel_q[i] <= IselMax) ? in_ext[insel_q[i]] : 1'b0;
   end

`ifdef PINMUX_DEBOUNCE_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         debounce_q <= '0;
      end else if (wr_en && hit_db) begin
         debounce_q <= reg_wdata_i[DebounceW-1:0];
      end
   end

   for (genvar i = 0; i < NPeriphIn; i++) begin : g_db
      logic [DebounceW-1:0] cnt_q;
      logic                 db_q;
      logic                 clr;

      assign clr = wr_en && hit_in && (in_idx == InIdxW'(i));

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
         end else if (debounce_q == '0) begin
            // Track the raw value so enabling debounce later starts from the visible state.
            cnt_q <= '0;
            db_q  <= muxed[i];
         end else if (clr || (muxed[i] == db_q)) begin
            cnt_q <= '0;
         end else if (cnt_q >= debounce_q - DebounceW'(1)) begin
            cnt_q <= '0;
            db_q  <= muxed[i];
         end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + DebounceW'(1);
         end
      end

      assign periph_in_o[i] = (debounce_q == '0) ? muxed[i] : db_q;
   end
`else
   assign periph_in_o = muxed;
`endif

   logic unused_bits;
   assign unused_bits = ^{reg_addr_i[1:0], reg_wdata_i};

endmodule

// File: tb/tb_pinmux_cfg.sv
// Self-checking bench for pinmux_cfg: register vector table plus hand-written
// sequences for the output/input paths, lock, reset and (when built with it) debounce.
module tb_pinmux_cfg;

   localparam int NPads      = 64;
   localparam int NPeriphOut = 64;
   localparam int NPeriphIn  = 48;
   localparam int NV         = 21;

`ifdef PINMUX_DEBOUNCE_EN
   localparam logic [31:0] DbRead = 32'd4;
`else
   localparam logic [31:0] DbRead = 32'd0;
`endif

   logic                  clk_i;
   logic                  rst_ni;
   logic                  reg_req_i;
   logic                  reg_we_i;
   logic [11:0]           reg_addr_i;
   logic [31:0]           reg_wdata_i;
   logic [31:0]           reg_rdata_o;
   logic                  reg_ready_o;
   logic                  reg_err_o;
   logic [NPeriphOut-1:0] periph_out_i;
   logic [NPeriphOut-1:0] periph_oe_i;
   logic [NPeriphIn-1:0]  periph_in_o;
   logic [NPads-1:0]      pad_in_i;
   logic [NPads-1:0]      pad_out_o;
   logic [NPads-1:0]      pad_oe_o;
   logic                  locked_o;

   pinmux_cfg #(
      .NPads(NPads), .NPeriphOut(NPeriphOut), .NPeriphIn(NPeriphIn), .DebounceW(8)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .reg_req_i(reg_req_i), .reg_we_i(reg_we_i), .reg_addr_i(reg_addr_i),
      .reg_wdata_i(reg_wdata_i), .reg_rdata_o(reg_rdata_o), .reg_ready_o(reg_ready_o),
      .reg_err_o(reg_err_o),
      .periph_out_i(periph_out_i), .periph_oe_i(periph_oe_i), .periph_in_o(periph_in_o),
      .pad_in_i(pad_in_i), .pad_out_o(pad_out_o), .pad_oe_o(pad_oe_o),
      .locked_o(locked_o)
   );

   // Clock and reset
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;
   logic [32:0] exp_q[$];
   logic [32:0] mon_e;
   logic        due;

   logic [6:0] outsel_m [NPads];
   logic [6:0] insel_m  [NPeriphIn];

   typedef struct {
      logic        we;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs [NV];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: one response expected per request accepted on the previous edge
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) due <= 1'b0;
      else         due <= reg_req_i;
   end

   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (due) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL resp_queue: response due with empty expected queue at %0t", $time);
            end else begin
               mon_e = exp_q.pop_front();
               check("resp_ready", 64'(reg_ready_o), 64'(1'b1));
               check("resp_err",   64'(reg_err_o),   64'(mon_e[32]));
               check("resp_rdata", 64'(reg_rdata_o), 64'(mon_e[31:0]));
            end
         end else begin
            check("idle_resp", 64'({reg_ready_o, reg_err_o, reg_rdata_o}), 64'(0));
         end
      end
   end

   // Driver tasks
   task automatic reg_access(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                             input logic err, input logic [31:0] rdata);
      reg_req_i   = 1'b1;
      reg_we_i    = we;
      reg_addr_i  = addr;
      reg_wdata_i = wdata;
      exp_q.push_back({err, rdata});
      @(posedge clk_i);
      #1;
      reg_req_i   = 1'b0;
      reg_we_i    = 1'b0;
      reg_addr_i  = '0;
      reg_wdata_i = '0;
   endtask

   function automatic vec_t mk(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                               input logic err, input logic [31:0] rdata);
      vec_t v;
      v.we = we; v.addr = addr; v.wdata = wdata; v.err = err; v.rdata = rdata;
      return v;
   endfunction

   task automatic check_pads(input string tag);
      logic [NPads-1:0] eo, ee;
      int k;
      for (int p = 0; p < NPads; p++) begin
         k = int'(outsel_m[p]);
         if (k >= 1 && k <= NPeriphOut) begin
            eo[p] = periph_out_i[k-1];
            ee[p] = periph_oe_i[k-1];
         end else begin
            eo[p] = 1'b0;
            ee[p] = 1'b0;
         end
      end
      check({tag, "_pad_out"}, 64'(pad_out_o), 64'(eo));
      check({tag, "_pad_oe"},  64'(pad_oe_o),  64'(ee));
   endtask

   function automatic logic [NPeriphIn-1:0] exp_in();
      logic [NPeriphIn-1:0] r;
      int k;
      for (int i = 0; i < NPeriphIn; i++) begin
         k = int'(insel_m[i]);
         if (k == 1)                      r[i] = 1'b1;
         else if (k >= 2 && k <= NPads+1) r[i] = pad_in_i[k-2];
         else                             r[i] = 1'b0;
      end
      return r;
   endfunction

   task automatic clear_model();
      for (int p = 0; p < NPads; p++)     outsel_m[p] = '0;
      for (int i = 0; i < NPeriphIn; i++) insel_m[i]  = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_ni = 1'b0; reg_req_i = 1'b0; reg_we_i = 1'b0; reg_addr_i = '0; reg_wdata_i = '0;
      periph_out_i = '0; periph_oe_i = '0; pad_in_i = '0;
      clear_model();

      vecs[0]  = mk(1'b0, 12'h014, 32'h0,        1'b0, 32'h0);   // OUTSEL[5]
      vecs[1]  = mk(1'b0, 12'h40C, 32'h0,        1'b0, 32'h0);   // INSEL[3]
      vecs[2]  = mk(1'b1, 12'h028, 32'd3,        1'b0, 32'h0);   // OUTSEL[10]=3
      vecs[3]  = mk(1'b0, 12'h028, 32'h0,        1'b0, 32'd3);
      vecs[4]  = mk(1'b1, 12'h02C, 32'hFFFFFF41, 1'b0, 32'h0);   // OUTSEL[11]=65 (off)
      vecs[5]  = mk(1'b0, 12'h02C, 32'h0,        1'b0, 32'h41);
      vecs[6]  = mk(1'b1, 12'h030, 32'd64,       1'b0, 32'h0);   // OUTSEL[12]=last periph
      vecs[7]  = mk(1'b1, 12'h41C, 32'd9,        1'b0, 32'h0);   // INSEL[7]=pad 7
      vecs[8]  = mk(1'b0, 12'h41C, 32'h0,        1'b0, 32'd9);
      vecs[9]  = mk(1'b1, 12'h4BC, 32'd65,       1'b0, 32'h0);   // INSEL[47]=pad 63
      vecs[10] = mk(1'b1, 12'h4B8, 32'd66,       1'b0, 32'h0);   // INSEL[46]=66 (const 0)
      vecs[11] = mk(1'b0, 12'h900, 32'h0,        1'b1, 32'h0);
      vecs[12] = mk(1'b1, 12'h4C0, 32'd5,        1'b1, 32'h0);   // INSEL[48]
      vecs[13] = mk(1'b0, 12'h100, 32'h0,        1'b1, 32'h0);   // OUTSEL[64]
      vecs[14] = mk(1'b0, 12'hC00, 32'h0,        1'b1, 32'h0);
      vecs[15] = mk(1'b0, 12'h02B, 32'h0,        1'b0, 32'd3);   // byte bits ignored
      vecs[16] = mk(1'b1, 12'h804, 32'd4,        1'b0, 32'h0);
      vecs[17] = mk(1'b0, 12'h804, 32'h0,        1'b0, DbRead);
      vecs[18] = mk(1'b1, 12'h804, 32'd0,        1'b0, 32'h0);
      vecs[19] = mk(1'b0, 12'h800, 32'h0,        1'b0, 32'h0);
      vecs[20] = mk(1'b0, 12'h808, 32'h0,        1'b1, 32'h0);

      repeat (2) @(negedge clk_i);
      check("rst_ready", 64'(reg_ready_o), 64'(0));
      check("rst_pad_oe", 64'(pad_oe_o), 64'(0));
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      @(negedge clk_i);
      check("post_rst_outs", 64'({pad_out_o, pad_oe_o} != '0), 64'(0));
      check("post_rst_in_lock", 64'({periph_in_o, locked_o}), 64'(0));
      @(posedge clk_i); #1;

      // Register table, issued back to back
      for (int n = 0; n < NV; n++) begin
         reg_access(vecs[n].we, vecs[n].addr, vecs[n].wdata, vecs[n].err, vecs[n].rdata);
         if (vecs[n].we && !vecs[n].err) begin
            if (vecs[n].addr[11:10] == 2'b00) outsel_m[int'(vecs[n].addr[9:2])] = vecs[n].wdata[6:0];
            if (vecs[n].addr[11:10] == 2'b01) insel_m[int'(vecs[n].addr[9:2])]  = vecs[n].wdata[6:0];
         end
      end
      @(negedge clk_i);

      // Output path
      for (int n = 0; n < 4; n++) begin
         periph_out_i = {$urandom, $urandom};
         periph_oe_i  = {$urandom, $urandom};
         if (n == 0) begin
            periph_out_i[2] = 1'b1;
            periph_oe_i[2]  = 1'b1;
         end
         @(negedge clk_i);
         if (n == 0) check("pad10_out", 64'({pad_out_o[10], pad_oe_o[10]}), 64'(2'b11));
         check_pads("out_rand");
      end
      @(posedge clk_i); #1;
      reg_access(1'b1, 12'h028, 32'd0, 1'b0, 32'h0);
      outsel_m[10] = '0;
      @(negedge clk_i);
      check("pad10_off", 64'({pad_out_o[10], pad_oe_o[10]}), 64'(0));
      check_pads("out_off");

      // Input path latency and selects
      @(posedge clk_i); #1;
      pad_in_i[7] = 1'b1;
      @(negedge clk_i); check("in_lat0", 64'(periph_in_o[7]), 64'(0));
      @(negedge clk_i); check("in_lat1", 64'(periph_in_o[7]), 64'(0));
      @(negedge clk_i); check("in_lat2", 64'(periph_in_o[7]), 64'(1));
      for (int n = 0; n < 3; n++) begin
         @(posedge clk_i); #1;
         pad_in_i = {$urandom, $urandom};
         if (n == 0) pad_in_i[63] = 1'b1;
         repeat (3) @(negedge clk_i);
         check("in_rand", 64'(periph_in_o), 64'(exp_in()));
      end
      @(posedge clk_i); #1;
      reg_access(1'b1, 12'h41C, 32'd1, 1'b0, 32'h0);
      insel_m[7] = 7'd1;
      pad_in_i[7] = 1'b0;
      repeat (3) @(negedge clk_i);
      check("in_const1", 64'(periph_in_o[7]), 64'(1));
      check("in_all", 64'(periph_in_o), 64'(exp_in()));

      // Lock
      @(posedge clk_i); #1;
      reg_access(1'b1, 12'h800, 32'd1, 1'b0, 32'h0);
      reg_access(1'b0, 12'h800, 32'h0, 1'b0, 32'd1);
      reg_access(1'b1, 12'h000, 32'd4, 1'b1, 32'h0);
      reg_access(1'b0, 12'h000, 32'h0, 1'b0, 32'h0);
      reg_access(1'b1, 12'h400, 32'd5, 1'b1, 32'h0);
      reg_access(1'b1, 12'h804, 32'd1, 1'b1, 32'h0);
      reg_access(1'b0, 12'h41C, 32'h0, 1'b0, 32'd1);
      reg_access(1'b1, 12'h800, 32'd0, 1'b0, 32'h0);
      reg_access(1'b0, 12'h800, 32'h0, 1'b0, 32'd1);
      @(negedge clk_i);
      check("locked", 64'(locked_o), 64'(1));
      check_pads("locked");
      check("locked_in", 64'(periph_in_o), 64'(exp_in()));

      // Reset lands while a response is pending: it must be dropped
      @(posedge clk_i); #1;
      reg_req_i = 1'b1; reg_we_i = 1'b0; reg_addr_i = 12'h800;
      @(posedge clk_i); #1;
      reg_req_i = 1'b0; reg_addr_i = '0;
      #1;
      rst_ni = 1'b0;
      exp_q.delete();
      clear_model();
      pad_in_i = '0;
      @(negedge clk_i);
      check("mid_rst_resp", 64'({reg_ready_o, reg_err_o, reg_rdata_o}), 64'(0));
      check("mid_rst_lock", 64'(locked_o), 64'(0));
      check_pads("mid_rst");
      check("mid_rst_in", 64'(periph_in_o), 64'(0));
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      repeat (3) @(negedge clk_i);
      @(posedge clk_i); #1;
      reg_access(1'b0, 12'h800, 32'h0, 1'b0, 32'h0);
      reg_access(1'b0, 12'h028, 32'h0, 1'b0, 32'h0);
      reg_access(1'b0, 12'h41C, 32'h0, 1'b0, 32'h0);
      @(negedge clk_i);
      check("unlocked", 64'(locked_o), 64'(0));

`ifdef PINMUX_DEBOUNCE_EN
      // Debounce: threshold 4 on INSEL[20] <- pad 30
      @(posedge clk_i); #1;
      reg_access(1'b1, 12'h804, 32'd4, 1'b0, 32'h0);
      reg_access(1'b1, 12'h450, 32'd32, 1'b0, 32'h0);
      repeat (3) @(posedge clk_i);
      #1;
      pad_in_i[30] = 1'b1;
      repeat (3) begin
         @(posedge clk_i); #1;
      end
      pad_in_i[30] = 1'b0;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk_i);
         check("db_glitch", 64'(periph_in_o[20]), 64'(0));
      end
      @(posedge clk_i); #1;
      pad_in_i[30] = 1'b1;
      for (int j = 0; j < 7; j++) begin
         @(negedge clk_i);
         check("db_steady", 64'(periph_in_o[20]), 64'(j == 6));
      end
`endif

      repeat (2) @(negedge clk_i);
      check("queue_drain", 64'(exp_q.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
